// File: rtl/frontend_frame_tx.sv
// Frontend frame transmitter: arbitrates cmd/timetag/singles words and
// serializes each padded frame MSB-first over LINES data lines.
module frontend_frame_tx #(
   parameter int LENGTH    = 128,
   parameter int LINES     = 3,
   parameter int CMD_LEN   = 32,
   parameter int TT_PERIOD = 1000,
   parameter int GAP       = 2
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [LENGTH-1:0]  sgl_data,
   input  logic               sgl_valid,
   output logic               sgl_ready,
   input  logic [CMD_LEN-1:0] cmd_data,
   input  logic               cmd_valid,
   output logic               cmd_ready,
   input  logic               tt_en,
   output logic [LINES-1:0]   d,
   output logic               busy,
   output logic [15:0]        tt_missed
);

   localparam int BPL = (LENGTH + LINES - 1) / LINES;
   localparam int PW  = BPL * LINES;
   localparam int BW  = (BPL > 1) ? $clog2(BPL) : 1;
   localparam int GW  = (GAP > 1) ? $clog2(GAP) : 1;
   localparam int PCW = (TT_PERIOD > 1) ? $clog2(TT_PERIOD) : 1;

   typedef enum logic [1:0] {
      IDLE,
      START,
      DATA,
      GAPS
   } state_t;

   state_t           state;
   logic [PW-1:0]    shreg;
   logic [BW-1:0]    beat;
   logic [GW-1:0]    gap_cnt;
   logic [47:0]      timetag;
   logic [PCW-1:0]   per_cnt;
   logic             tt_pending;

   logic             idle;
   logic             tt_take;
   logic             sgl_take;
   logic             accept;
   logic             per_wrap;
   logic [LENGTH-1:0] frame;
   logic [LINES-1:0] beat_bits;

   assign idle      = (state == IDLE);
   assign cmd_ready = idle & cmd_valid;
   assign sgl_ready = idle & ~cmd_valid & ~tt_pending;
   assign tt_take   = idle & ~cmd_valid & tt_pending;
   assign sgl_take  = sgl_ready & sgl_valid;
   assign accept    = cmd_ready | tt_take | sgl_take;
   assign busy      = ~idle;
   assign per_wrap  = (per_cnt == PCW'(TT_PERIOD - 1));

   always_comb begin
      frame = '0;
      unique case (1'b1)
         cmd_ready: begin
            frame[115]         = 1'b1;
            frame[CMD_LEN-1:0] = cmd_data;
         end
         tt_take: begin
            frame[47:0] = timetag;
         end
         sgl_take: begin
            frame      = sgl_data;
            frame[122] = 1'b1;
         end
         default: begin
            frame = '0;
         end
      endcase
   end

   // line 0 always carries the most significant bit of the beat
   always_comb begin
      beat_bits = '0;
      for (int j = 0; j < LINES; j++) begin
         beat_bits[j] = shreg[PW-1-j];
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         timetag    <= '0;
         per_cnt    <= '0;
         tt_pending <= 1'b0;
         tt_missed  <= '0;
      end else begin
         timetag <= timetag + 48'd1;
         per_cnt <= per_wrap ? '0 : per_cnt + PCW'(1);
         // a wrap coinciding with the TT latch re-arms, it is not a miss
         if (per_wrap && tt_en) begin
            tt_pending <= 1'b1;
            if (tt_pending && !tt_take && tt_missed != 16'hFFFF) begin
               tt_missed <= tt_missed + 16'd1;
            end
         end else if (tt_take) begin
            tt_pending <= 1'b0;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= IDLE;
         d       <= '1;
         shreg   <= '0;
         beat    <= '0;
         gap_cnt <= '0;
      end else begin
         unique case (state)
            IDLE: begin
               d <= '1;
               if (accept) begin
                  shreg <= PW'(frame);
                  d     <= '0;
                  state <= START;
               end
            end
            START: begin
               d     <= beat_bits;
               shreg <= shreg << LINES;
               beat  <= '0;
               state <= DATA;
            end
            DATA: begin
               if (beat == BW'(BPL - 1)) begin
                  d       <= '1;
                  gap_cnt <= '0;
                  state   <= GAPS;
               end else begin
                  d     <= beat_bits;
                  shreg <= shreg << LINES;
                  beat  <= beat + BW'(1);
               end
            end
            GAPS: begin
               d <= '1;
               if (gap_cnt == GW'(GAP - 1)) begin
                  state <= IDLE;
               end else begin
                  gap_cnt <= gap_cnt + GW'(1);
               end
            end
            default: begin
               d     <= '1;
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_frontend_frame_tx.sv
// Scoreboard bench for frontend_frame_tx: a cycle-level reference model
// predicts handshakes and frames, a line monitor deserializes and compares.
module tb_frontend_frame_tx;

   localparam int LENGTH    = 128;
   localparam int LINES     = 3;
   localparam int CMD_LEN   = 32;
   localparam int TT_PERIOD = 100;
   localparam int GAP       = 2;
   localparam int BPL       = (LENGTH + LINES - 1) / LINES;
   localparam int PW        = BPL * LINES;
   localparam int FRAME_CYC = 1 + BPL + GAP;

   logic               clk = 1'b0;
   logic               rst;
   logic [LENGTH-1:0]  sgl_data;
   logic               sgl_valid;
   logic               sgl_ready;
   logic [CMD_LEN-1:0] cmd_data;
   logic               cmd_valid;
   logic               cmd_ready;
   logic               tt_en;
   logic [LINES-1:0]   d;
   logic               busy;
   logic [15:0]        tt_missed;

   frontend_frame_tx #(
      .LENGTH(LENGTH), .LINES(LINES), .CMD_LEN(CMD_LEN),
      .TT_PERIOD(TT_PERIOD), .GAP(GAP)
   ) dut (
      .clk(clk), .rst(rst),
      .sgl_data(sgl_data), .sgl_valid(sgl_valid), .sgl_ready(sgl_ready),
      .cmd_data(cmd_data), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
      .tt_en(tt_en), .d(d), .busy(busy), .tt_missed(tt_missed)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [PW-1:0] p;
      int            acc;
   } exp_t;

   exp_t        q[$];
   logic [47:0] tt_pl[$];
   int          errors = 0;
   int          checks = 0;
   int          cyc = 0;
   bit          armed = 0;

   task automatic chk(input string nm, input logic [PW-1:0] act,
                      input logic [PW-1:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s cyc=%0d actual=%h required=%h", nm, cyc, act, req);
      end
   endtask

   task automatic fail_now(input string nm);
      checks++;
      errors++;
      $display("FAIL %s cyc=%0d actual=timeout required=event", nm, cyc);
   endtask

   always @(posedge clk) cyc++;

   // reference model: values below describe the current cycle
   logic [47:0] m_tt;
   int          m_per;
   bit          m_pend;
   int          m_missed;
   int          m_rem;

   always @(negedge clk) begin
      bit            idle;
      bit            took_tt;
      bit            acc;
      bit            wrap;
      logic [LENGTH-1:0] f;
      exp_t          ne;
      if (rst) begin
         armed    = 1;
         m_tt     = '0;
         m_per    = 0;
         m_pend   = 0;
         m_missed = 0;
         m_rem    = 0;
         q.delete();
      end else if (armed) begin
         idle = (m_rem == 0);
         chk("busy", PW'(busy), PW'(!idle));
         chk("cmd_ready", PW'(cmd_ready), PW'(idle && cmd_valid));
         chk("sgl_ready", PW'(sgl_ready), PW'(idle && !cmd_valid && !m_pend));
         chk("tt_missed", PW'(tt_missed), PW'(m_missed));
         took_tt = 0;
         acc     = 0;
         f       = '0;
         if (idle) begin
            if (cmd_valid) begin
               f[115]         = 1'b1;
               f[CMD_LEN-1:0] = cmd_data;
               acc            = 1;
            end else if (m_pend) begin
               f[47:0] = m_tt;
               took_tt = 1;
               acc     = 1;
            end else if (sgl_valid) begin
               f      = sgl_data;
               f[122] = 1'b1;
               acc    = 1;
            end
         end
         if (acc) begin
            ne.p = PW'(f);
            ne.acc = cyc;
            q.push_back(ne);
            m_rem = FRAME_CYC;
         end else if (m_rem > 0) begin
            m_rem--;
         end
         wrap = (m_per == TT_PERIOD - 1);
         m_per = wrap ? 0 : m_per + 1;
         m_tt  = m_tt + 48'd1;
         if (wrap && tt_en) begin
            if (m_pend && !took_tt && m_missed < 16'hFFFF) m_missed++;
            m_pend = 1;
         end else if (took_tt) begin
            m_pend = 0;
         end
      end
   end

   // line monitor
   int            ms = 0;
   int            mbeat;
   int            mgap;
   bit            have_e;
   logic [PW-1:0] word;
   exp_t          e;

   always @(negedge clk) begin
      if (rst) begin
         ms = 0;
      end else if (armed) begin
         case (ms)
            0: begin
               if (d !== '1) begin
                  chk("start_d", PW'(d), PW'(0));
                  have_e = (q.size() != 0);
                  if (have_e) begin
                     e = q.pop_front();
                     chk("start_cycle", PW'(cyc), PW'(e.acc + 1));
                  end else begin
                     fail_now("unexpected_frame");
                  end
                  word  = '0;
                  mbeat = 0;
                  ms    = 1;
               end
            end
            1: begin
               for (int j = 0; j < LINES; j++) begin
                  word[PW-1-(mbeat*LINES+j)] = d[j];
               end
               mbeat++;
               if (mbeat == BPL) begin
                  mgap = 0;
                  ms   = 2;
               end
            end
            default: begin
               chk("gap_d", PW'(d), PW'(3'b111));
               mgap++;
               if (mgap == GAP) begin
                  if (have_e) chk("frame", word, e.p);
                  if (!word[115] && !word[122]) tt_pl.push_back(word[47:0]);
                  ms = 0;
               end
            end
         endcase
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_sgl(output int acc_cyc);
      int n;
      n = 0;
      acc_cyc = -1;
      while (n < 300) begin
         @(negedge clk);
         n++;
         if (sgl_ready) begin
            acc_cyc = cyc;
            break;
         end
      end
      if (acc_cyc < 0) fail_now("sgl_accept");
      tick();
      sgl_valid = 1'b0;
   endtask

   task automatic wait_cmd(output int acc_cyc);
      int n;
      n = 0;
      acc_cyc = -1;
      while (n < 300) begin
         @(negedge clk);
         n++;
         if (cmd_ready) begin
            acc_cyc = cyc;
            break;
         end
      end
      if (acc_cyc < 0) fail_now("cmd_accept");
      tick();
      cmd_valid = 1'b0;
   endtask

   task automatic wait_idle();
      int n;
      n = 0;
      do begin
         tick();
         n++;
      end while (!(busy == 1'b0 && q.size() == 0 && ms == 0 && !m_pend)
                 && n < 2000);
      if (n >= 2000) fail_now("drain");
   endtask

   task automatic rand_sgl();
      sgl_data = {$urandom, $urandom, $urandom, $urandom};
   endtask

   initial begin
      int n_acc;
      int c_acc;
      int s_acc;
      int n;
      rst       = 1'b1;
      sgl_valid = 1'b0;
      cmd_valid = 1'b0;
      sgl_data  = '0;
      cmd_data  = '0;
      tt_en     = 1'b0;
      repeat (3) tick();
      rst = 1'b0;
      @(negedge clk);
      chk("rst_d", PW'(d), PW'(3'b111));
      chk("rst_busy", PW'(busy), PW'(0));
      chk("rst_missed", PW'(tt_missed), PW'(0));
      tick();

      // single singles word
      sgl_data  = 128'h0123_4567_89AB_CDEF_0011_2233_4455_6677;
      sgl_valid = 1'b1;
      wait_sgl(n_acc);
      wait_idle();

      // cmd and singles together: cmd wins, singles after full frame
      cmd_data  = 32'hDEADBEEF;
      cmd_valid = 1'b1;
      rand_sgl();
      sgl_valid = 1'b1;
      wait_cmd(c_acc);
      wait_sgl(s_acc);
      chk("sgl_after_cmd", PW'(s_acc - c_acc), PW'(45 + GAP));
      wait_idle();

      // periodic timetags, no other traffic
      tt_pl.delete();
      tt_en = 1'b1;
      repeat (350) tick();
      tt_en = 1'b0;
      wait_idle();
      chk("tt_count", PW'(tt_pl.size() >= 3), PW'(1));
      for (int i = 1; i < tt_pl.size(); i++) begin
         chk("tt_spacing", PW'(tt_pl[i] - tt_pl[i-1]), PW'(TT_PERIOD));
      end

      // commands hog the link so timetag ticks are lost
      tt_en     = 1'b1;
      cmd_valid = 1'b1;
      for (int i = 0; i < 350; i++) begin
         cmd_data = $urandom;
         tick();
      end
      cmd_valid = 1'b0;
      tt_en     = 1'b0;
      wait_idle();

      // reset in the middle of beat 20
      rand_sgl();
      sgl_valid = 1'b1;
      wait_sgl(n_acc);
      while (cyc < n_acc + 22) tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      @(negedge clk);
      chk("midrst_d", PW'(d), PW'(3'b111));
      chk("midrst_busy", PW'(busy), PW'(0));
      chk("midrst_missed", PW'(tt_missed), PW'(0));
      tick();
      rand_sgl();
      sgl_valid = 1'b1;
      wait_sgl(n_acc);
      wait_idle();

      // timetag counter wrap inside a TT frame
      tt_pl.delete();
      tt_en = 1'b1;
      n = 0;
      while (!(m_per == TT_PERIOD - 3 && m_rem == 0 && !m_pend) && n < 600) begin
         tick();
         n++;
      end
      if (n >= 600) fail_now("wrap_setup");
      dut.timetag = 48'hFFFF_FFFF_FFFD;
      m_tt        = 48'hFFFF_FFFF_FFFD;
      repeat (10) tick();
      tt_en = 1'b0;
      wait_idle();
      chk("wrap_frames", PW'(tt_pl.size() >= 1), PW'(1));
      if (tt_pl.size() >= 1) chk("wrap_payload", PW'(tt_pl[0]), PW'(0));

      // randomized mixed traffic
      tt_en = 1'b1;
      for (int i = 0; i < 4000; i++) begin
         cmd_valid = ($urandom_range(0, 99) < 3);
         cmd_data  = $urandom;
         sgl_valid = ($urandom_range(0, 99) < 40);
         rand_sgl();
         if ($urandom_range(0, 299) == 0) tt_en = ~tt_en;
         tick();
      end
      cmd_valid = 1'b0;
      sgl_valid = 1'b0;
      tt_en     = 1'b0;
      wait_idle();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
